// File: rtl/counter_pkg.sv
// counter_pkg: types and helpers shared by the up-counter build, its checker and the bench.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents:
//   COUNT_W     default width of the counter's count output
//   chk_state_t checker FSM encoding (IDLE, CHECK, HALT)
//   next_count  counter next-state rule; reset has priority over enable
package counter_pkg;

  localparam int COUNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_HALT  = 2'd2
  } chk_state_t;

  // Works on a 32-bit container so any count width up to 32 can use it.
  // The caller truncates the result to its own width, which yields the
  // modulo-2^WIDTH wrap for free.
  function automatic logic [31:0] next_count(input logic        rst,
                                             input logic        en,
                                             input logic [31:0] cnt);
    logic [31:0] res;
    if (rst) begin
      res = '0;
    end else if (en) begin
      res = cnt + 32'd1;
    end else begin
      res = cnt;
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
// Latency: increment is visible one clock after i_inc.
// Backpressure: none; i_inc is accepted every cycle, and i_clr wins over i_inc.
//
// Ports:
//   i_clk    clock
//   i_clr    synchronous clear, active high
//   i_inc    increment request
//   o_count  current count
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = (r_count == {WIDTH{1'b1}});

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !w_at_max) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/count_checker.sv
// count_checker: watches an up-counter's inputs and output and flags every transition that breaks the counting rule.
// Latency: obs_count is judged in cycle t; mismatch/err_count/fail/first_fail_cyc/wrap_seen show it in cycle t+1.
// Backpressure: none; this block only observes and samples every cycle.
//
// Ports:
//   clk, rst          clock and synchronous active-high checker reset
//   obs_rst, obs_en   counter's rst/en inputs as driven to it
//   obs_count         counter's registered count output
//   armed             prediction valid, checking active
//   expected          prediction for the current obs_count
//   mismatch          one-cycle pulse per failing comparison
//   fail              sticky, set on the first mismatch
//   err_count         saturating mismatch tally
//   first_fail_cyc    cycle stamp of the first mismatch
//   wrap_seen         one-cycle pulse after a correct all-ones -> 0 wrap
module count_checker
  import counter_pkg::*;
#(
  parameter int WIDTH        = COUNT_W,
  parameter int ERR_W        = 8,
  parameter int CYC_W        = 16,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             obs_rst,
  input  logic             obs_en,
  input  logic [WIDTH-1:0] obs_count,
  output logic             armed,
  output logic [WIDTH-1:0] expected,
  output logic             mismatch,
  output logic             fail,
  output logic [ERR_W-1:0] err_count,
  output logic [CYC_W-1:0] first_fail_cyc,
  output logic             wrap_seen
);

  chk_state_t       r_state;
  chk_state_t       w_state_nxt;

  // Last cycle's view of the counter; the prediction is derived from these.
  logic             r_prev_rst;
  logic             r_prev_en;
  logic [WIDTH-1:0] r_prev_count;

  logic             r_mismatch;
  logic             r_fail;
  logic             r_wrap_seen;
  logic [CYC_W-1:0] r_first_fail_cyc;

  logic [WIDTH-1:0] w_expected;
  logic [CYC_W-1:0] w_cyc;
  logic             w_cmp_bad;
  logic             w_wrap_cond;
  logic             w_armed;
  logic             w_capture;
  logic             w_mismatch;
  logic             w_wrap;

  assign w_expected = WIDTH'(next_count(r_prev_rst, r_prev_en, 32'(r_prev_count)));

  // Case inequality so an unknown observed bit is reported as a mismatch
  // rather than silently passing in a four-state simulator.
  assign w_cmp_bad = (obs_count !== w_expected);

  // A correct wrap is the only way to reach 0 from all-ones with enable set
  // and no reset, so the prediction itself must be 0 here.
  assign w_wrap_cond = (r_prev_count == {WIDTH{1'b1}}) && r_prev_en && !r_prev_rst &&
                       (obs_count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_armed     = 1'b0;
    w_capture   = 1'b0;
    w_mismatch  = 1'b0;
    w_wrap      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // No prediction exists yet; just take the first sample.
        w_capture   = 1'b1;
        w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        w_armed    = 1'b1;
        w_capture  = 1'b1;
        w_mismatch = w_cmp_bad;
        w_wrap     = w_wrap_cond && !w_cmp_bad;
        if (w_cmp_bad && (STOP_ON_FAIL != 0)) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        // Frozen until the checker is reset.
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Samples track what was observed, not what was predicted, so after a bad
  // transition checking resynchronises and each fault is counted once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_rst   <= 1'b0;
      r_prev_en    <= 1'b0;
      r_prev_count <= '0;
    end else if (w_capture) begin
      r_prev_rst   <= obs_rst;
      r_prev_en    <= obs_en;
      r_prev_count <= obs_count;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mismatch       <= 1'b0;
      r_wrap_seen      <= 1'b0;
      r_fail           <= 1'b0;
      r_first_fail_cyc <= '0;
    end else begin
      r_mismatch  <= w_mismatch;
      r_wrap_seen <= w_wrap;
      if (w_mismatch) begin
        r_fail <= 1'b1;
        if (!r_fail) begin
          r_first_fail_cyc <= w_cyc;
        end
      end
    end
  end

  sat_counter #(
    .WIDTH (ERR_W)
  ) u_err_cnt (
    .i_clk   (clk),
    .i_clr   (rst),
    .i_inc   (w_mismatch),
    .o_count (err_count)
  );

  // Counts edges spent in CHECK: reads 0 during the first CHECK cycle.
  sat_counter #(
    .WIDTH (CYC_W)
  ) u_cyc_cnt (
    .i_clk   (clk),
    .i_clr   (rst),
    .i_inc   (w_armed),
    .o_count (w_cyc)
  );

  assign armed          = w_armed;
  assign expected       = w_expected;
  assign mismatch       = r_mismatch;
  assign fail           = r_fail;
  assign first_fail_cyc = r_first_fail_cyc;
  assign wrap_seen      = r_wrap_seen;

endmodule
